// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-port AXI3 read arbiter.
//   state_e      : arbiter FSM states (IDLE / ADDR / DATA)
//   BURST_INCR   : AXI ARBURST encoding for incrementing bursts
//   RESP_OKAY    : AXI RRESP encoding for a good beat
//   PORT_ICACHE  : requester id of the instruction cache (port 0)
//   PORT_DCACHE  : requester id of the data cache (port 1)
//   axsize()     : ARSIZE encoding for a beat of the given byte width
package axi_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic       PORT_ICACHE = 1'b0;
  localparam logic       PORT_DCACHE = 1'b1;

  function automatic logic [2:0] axsize(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Bus bundle around the read arbiter: two cache refill ports (s0 = I-cache,
// s1 = D-cache) and the shared AXI3 AR/R master port (m_*).
//   modport master : the arbiter's view (drives s*_arready, s*_r*, m_ar*, m_rready)
//   modport slave  : the environment's view (caches and interconnect)
interface axi_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();

  logic [ADDR_W-1:0] s0_araddr;
  logic              s0_arvalid;
  logic              s0_arready;
  logic [DATA_W-1:0] s0_rdata;
  logic              s0_rvalid;
  logic              s0_rlast;
  logic              s0_rready;

  logic [ADDR_W-1:0] s1_araddr;
  logic              s1_arvalid;
  logic              s1_arready;
  logic [DATA_W-1:0] s1_rdata;
  logic              s1_rvalid;
  logic              s1_rlast;
  logic              s1_rready;

  logic [ADDR_W-1:0] m_araddr;
  logic [3:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic [ID_W-1:0]   m_arid;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [ID_W-1:0]   m_rid;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    input  s0_araddr, s0_arvalid, s0_rready,
    output s0_arready, s0_rdata, s0_rvalid, s0_rlast,
    input  s1_araddr, s1_arvalid, s1_rready,
    output s1_arready, s1_rdata, s1_rvalid, s1_rlast,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rid, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

  modport slave (
    output s0_araddr, s0_arvalid, s0_rready,
    input  s0_arready, s0_rdata, s0_rvalid, s0_rlast,
    output s1_araddr, s1_arvalid, s1_rready,
    input  s1_arready, s1_rdata, s1_rvalid, s1_rlast,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arvalid,
    output m_arready,
    output m_rdata, m_rid, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );

endinterface

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// Two-way round-robin grant.
//   req_i    : request vector, bit n = port n
//   ptr_i    : port favoured when both request
//   gnt_o    : one-hot grant (all zero when no request)
//   gnt_id_o : granted port number
//   any_o    : at least one request present
module rr_arbiter2
  import axi_read_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o,
  output logic       any_o
);

  always_comb begin
    any_o    = |req_i;
    gnt_id_o = PORT_ICACHE;
    if (req_i == 2'b11) begin
      gnt_id_o = ptr_i;
    end else if (req_i[1]) begin
      gnt_id_o = PORT_DCACHE;
    end
    gnt_o = '0;
    if (any_o) begin
      gnt_o[gnt_id_o] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read port between the I-cache (port 0) and D-cache
// (port 1). One burst at a time, round-robin between simultaneous requests.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache ports s0/s1 and AXI master port m (master modport)
//   busy     : a burst is in flight (FSM not idle)
//   err      : one-cycle pulse on a beat with bad RRESP, wrong RID, or
//              RLAST not coinciding with beat BURST_LEN
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int ID_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  axi_read_arbiter_if.master  bus,
  output logic                busy,
  output logic                err
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  state_e            state_q;
  logic              rr_ptr_q;
  logic              gnt_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]  beat_cnt_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       any_req;
  logic       in_idle;
  logic       in_data;
  logic       sel_rready;
  logic       beat_fire;
  logic       last_expected;

  assign req = {bus.s1_arvalid, bus.s0_arvalid};

  rr_arbiter2 u_rr (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (any_req)
  );

  // arready is combinational from IDLE; rst gates it so outputs are 0 during reset.
  assign in_idle = (state_q == ST_IDLE) && !rst;
  assign in_data = (state_q == ST_DATA);

  assign bus.s0_arready = in_idle && gnt[0];
  assign bus.s1_arready = in_idle && gnt[1];

  assign bus.m_araddr  = araddr_q;
  assign bus.m_arlen   = 4'(BURST_LEN - 1);
  assign bus.m_arsize  = axsize(int'(DATA_W / 8));
  assign bus.m_arburst = BURST_INCR;
  assign bus.m_arid    = ID_W'(gnt_q);
  assign bus.m_arvalid = arvalid_q;

  // R path is purely combinational toward the granted port only.
  assign sel_rready   = gnt_q ? bus.s1_rready : bus.s0_rready;
  assign bus.m_rready = in_data && sel_rready;

  assign bus.s0_rvalid = in_data && !gnt_q && bus.m_rvalid;
  assign bus.s1_rvalid = in_data &&  gnt_q && bus.m_rvalid;
  assign bus.s0_rdata  = (in_data && !gnt_q) ? bus.m_rdata : '0;
  assign bus.s1_rdata  = (in_data &&  gnt_q) ? bus.m_rdata : '0;
  assign bus.s0_rlast  = in_data && !gnt_q && bus.m_rlast;
  assign bus.s1_rlast  = in_data &&  gnt_q && bus.m_rlast;

  assign beat_fire     = bus.m_rvalid && bus.m_rready;
  assign beat_cnt_d    = beat_cnt_q + CNT_W'(1);
  assign last_expected = (beat_cnt_d == CNT_W'(BURST_LEN));

  assign err = beat_fire && ((bus.m_rresp != RESP_OKAY) ||
                             (bus.m_rid != ID_W'(gnt_q)) ||
                             (bus.m_rlast != last_expected));

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= PORT_ICACHE;
      gnt_q      <= PORT_ICACHE;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            araddr_q  <= gnt_id ? bus.s1_araddr : bus.s0_araddr;
            gnt_q     <= gnt_id;
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.m_arready) begin
            arvalid_q  <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            // Only RLAST ends the burst; a missing RLAST keeps counting.
            if (bus.m_rlast) begin
              beat_cnt_q <= '0;
              rr_ptr_q   <= ~gnt_q;
              state_q    <= ST_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: drives both cache ports and
// models the AXI slave; R beats are queued as expected results when a burst
// starts and popped as each beat reaches its cache.
module tb_axi_read_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int BURST_LEN = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_read_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .ID_W      (ID_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.s0_araddr = '0; bus.s0_arvalid = 1'b0; bus.s0_rready = 1'b0;
    bus.s1_araddr = '0; bus.s1_arvalid = 1'b0; bus.s1_rready = 1'b0;
    bus.m_arready = 1'b0; bus.m_rdata = '0; bus.m_rid = '0;
    bus.m_rresp = 2'b00; bus.m_rlast = 1'b0; bus.m_rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    init_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Starts in IDLE just after a clock edge; leaves the DUT in ADDR.
  task automatic request(input int port, input logic [31:0] addr);
    if (port == 0) begin bus.s0_araddr = addr; bus.s0_arvalid = 1'b1; end
    else           begin bus.s1_araddr = addr; bus.s1_arvalid = 1'b1; end
    @(negedge clk);
    checks++; if (bus.s0_arready !== (port == 0)) begin errors++; $display("FAIL req_s0_arready: got %b want %b", bus.s0_arready, port == 0); end
    checks++; if (bus.s1_arready !== (port == 1)) begin errors++; $display("FAIL req_s1_arready: got %b want %b", bus.s1_arready, port == 1); end
    checks++; if (bus.m_arvalid !== 1'b0) begin errors++; $display("FAIL req_arvalid_early: got %b want 0", bus.m_arvalid); end
    tick();
    bus.s0_arvalid = 1'b0;
    bus.s1_arvalid = 1'b0;
  endtask

  // Starts in ADDR; holds ARREADY low for 'delay' cycles; leaves the DUT in DATA.
  task automatic ar_channel(input int port, input logic [31:0] addr, input int delay);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      checks++; if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== addr) begin errors++; $display("FAIL ar_hold: arvalid %b addr %h want 1 %h", bus.m_arvalid, bus.m_araddr, addr); end
      tick();
    end
    bus.m_arready = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_arvalid !== 1'b1) begin errors++; $display("FAIL ar_valid: got %b want 1", bus.m_arvalid); end
    checks++; if (bus.m_araddr !== addr) begin errors++; $display("FAIL ar_addr: got %h want %h", bus.m_araddr, addr); end
    checks++; if (bus.m_arid !== ID_W'(port)) begin errors++; $display("FAIL ar_id: got %0d want %0d", bus.m_arid, port); end
    checks++; if (bus.m_arlen !== 4'd7 || bus.m_arsize !== 3'd2 || bus.m_arburst !== 2'b01) begin errors++; $display("FAIL ar_const: len %0d size %0d burst %b want 7 2 01", bus.m_arlen, bus.m_arsize, bus.m_arburst); end
    checks++; if (busy !== 1'b1 || bus.m_rready !== 1'b0) begin errors++; $display("FAIL ar_busy: busy %b rready %b want 1 0", busy, bus.m_rready); end
    tick();
    bus.m_arready = 1'b0;
  endtask

  // Starts in DATA; slave offers nbeats (data = base+n); RLAST on beat last_at,
  // RRESP=SLVERR on beat bad_resp_at. Ends one cycle after the final beat
  // (the IDLE cycle when the burst closed); idle_arready samples arready there.
  task automatic r_burst(input int port, input logic [31:0] base, input int nbeats,
                         input int last_at, input int bad_resp_at, input bit toggle,
                         output logic [1:0] idle_arready);
    int i;
    int cyc;
    logic rr, exp_err, mrr, obs_v, obs_l, oth_v, exp_busy;
    logic [31:0] obs_d;
    beat_t e;
    for (int k = 1; k <= nbeats; k++) sb.push_back('{base + 32'(k), k == last_at});
    i = 1;
    cyc = 0;
    while (i <= nbeats && cyc < 64) begin
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      if (port == 0) begin bus.s0_rready = rr; bus.s1_rready = 1'b1; end
      else           begin bus.s1_rready = rr; bus.s0_rready = 1'b1; end
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = base + 32'(i);
      bus.m_rlast  = (i == last_at);
      bus.m_rresp  = (i == bad_resp_at) ? 2'b10 : 2'b00;
      bus.m_rid    = ID_W'(port);
      exp_err = rr && ((i == bad_resp_at) || ((i == last_at) != (i == BURST_LEN)));
      @(negedge clk);
      mrr   = bus.m_rready;
      obs_v = (port == 0) ? bus.s0_rvalid : bus.s1_rvalid;
      obs_d = (port == 0) ? bus.s0_rdata  : bus.s1_rdata;
      obs_l = (port == 0) ? bus.s0_rlast  : bus.s1_rlast;
      oth_v = (port == 0) ? bus.s1_rvalid : bus.s0_rvalid;
      checks++; if (mrr !== rr) begin errors++; $display("FAIL r_mrready beat %0d: got %b want %b", i, mrr, rr); end
      checks++; if (obs_v !== 1'b1) begin errors++; $display("FAIL r_rvalid beat %0d: got %b want 1", i, obs_v); end
      checks++; if (oth_v !== 1'b0) begin errors++; $display("FAIL r_other_rvalid beat %0d: got %b want 0", i, oth_v); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL r_err beat %0d: got %b want %b", i, err, exp_err); end
      if (obs_v === 1'b1 && rr) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL r_unexpected_beat: got %h want none", obs_d);
        end else begin
          e = sb.pop_front();
          if (obs_d !== e.data || obs_l !== e.last) begin errors++; $display("FAIL r_data: got %h/%b want %h/%b", obs_d, obs_l, e.data, e.last); end
        end
      end
      tick();
      if (mrr === 1'b1) i++;
      cyc++;
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.m_rresp  = 2'b00;
    checks++; if (i <= nbeats) begin errors++; $display("FAIL r_timeout: got %0d beats want %0d", i - 1, nbeats); end
    @(negedge clk);
    exp_busy = !(last_at >= 1 && last_at <= nbeats);
    checks++; if (busy !== exp_busy) begin errors++; $display("FAIL r_busy_after: got %b want %b", busy, exp_busy); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL r_sb_left: got %0d want 0", sb.size()); end
    sb.delete();
    idle_arready = {bus.s1_arready, bus.s0_arready};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    bus.s0_arvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.s0_arready !== 1'b0 || bus.s1_arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b%b want 00", bus.s1_arready, bus.s0_arready); end
    checks++; if (bus.m_arvalid !== 1'b0 || bus.m_araddr !== '0 || bus.m_arid !== '0) begin errors++; $display("FAIL reset_ar: valid %b addr %h id %0d want 0", bus.m_arvalid, bus.m_araddr, bus.m_arid); end
    checks++; if (bus.m_rready !== 1'b0 || bus.s0_rvalid !== 1'b0 || bus.s1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_r: got %b%b%b want 000", bus.m_rready, bus.s0_rvalid, bus.s1_rvalid); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_status: busy %b err %b want 0 0", busy, err); end
    checks++; if (bus.m_arlen !== 4'd7 || bus.m_arsize !== 3'd2 || bus.m_arburst !== 2'b01) begin errors++; $display("FAIL reset_const: %0d %0d %b want 7 2 01", bus.m_arlen, bus.m_arsize, bus.m_arburst); end
    bus.s0_arvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] ira;
    request(0, 32'h0000_1040);
    ar_channel(0, 32'h0000_1040, 3);
    r_burst(0, 32'hC000_0000, 8, 8, 0, 1'b0, ira);
  endtask

  task automatic test_idle_rvalid();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEAD_BEEF; bus.m_rlast = 1'b1;
    bus.s0_rready = 1'b1; bus.s1_rready = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_rready !== 1'b0) begin errors++; $display("FAIL idle_mrready: got %b want 0", bus.m_rready); end
    checks++; if (bus.s0_rvalid !== 1'b0 || bus.s1_rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b%b err %b want 00 0", bus.s1_rvalid, bus.s0_rvalid, err); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_state: busy %b want 0", busy); end
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] ira;
    apply_reset();
    bus.s0_araddr = 32'h0000_3000; bus.s0_arvalid = 1'b1;
    bus.s1_araddr = 32'h0000_4000; bus.s1_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (bus.s0_arready !== 1'b1 || bus.s1_arready !== 1'b0) begin errors++; $display("FAIL rr_first: got %b%b want 01", bus.s1_arready, bus.s0_arready); end
    tick();
    bus.s0_arvalid = 1'b0;
    ar_channel(0, 32'h0000_3000, 1);
    r_burst(0, 32'hA000_0000, 8, 8, 0, 1'b0, ira);
    checks++; if (ira !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b want 10", ira); end
    bus.s1_arvalid = 1'b0;
    ar_channel(1, 32'h0000_4000, 0);
    r_burst(1, 32'hB000_0000, 8, 8, 0, 1'b0, ira);
    bus.s0_araddr = 32'h0000_5000; bus.s0_arvalid = 1'b1;
    bus.s1_araddr = 32'h0000_6000; bus.s1_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (bus.s0_arready !== 1'b1 || bus.s1_arready !== 1'b0) begin errors++; $display("FAIL rr_third: got %b%b want 01", bus.s1_arready, bus.s0_arready); end
    tick();
    bus.s0_arvalid = 1'b0;
    bus.s1_arvalid = 1'b0;
    ar_channel(0, 32'h0000_5000, 0);
    r_burst(0, 32'hA100_0000, 8, 8, 0, 1'b0, ira);
  endtask

  task automatic test_rready_toggle();
    logic [1:0] ira;
    request(1, 32'h0000_7700);
    ar_channel(1, 32'h0000_7700, 2);
    r_burst(1, 32'h5500_0000, 8, 8, 0, 1'b1, ira);
  endtask

  task automatic test_errors();
    logic [1:0] ira;
    request(0, 32'h0000_8000);
    ar_channel(0, 32'h0000_8000, 0);
    r_burst(0, 32'hE000_0000, 5, 5, 0, 1'b0, ira);
    request(1, 32'h0000_8100);
    ar_channel(1, 32'h0000_8100, 0);
    r_burst(1, 32'hE100_0000, 8, 8, 3, 1'b0, ira);
    request(0, 32'h0000_8200);
    ar_channel(0, 32'h0000_8200, 0);
    r_burst(0, 32'hE200_0000, 9, 9, 0, 1'b0, ira);
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] ira;
    request(1, 32'h0000_2080);
    ar_channel(1, 32'h0000_2080, 1);
    r_burst(1, 32'hD000_0000, 2, 0, 0, 1'b0, ira);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hD000_0003; bus.m_rid = ID_W'(1);
    bus.s1_rready = 1'b1; bus.s0_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (bus.s1_rvalid !== 1'b1) begin errors++; $display("FAIL mid_beat3_valid: got %b want 1", bus.s1_rvalid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.s1_rvalid !== 1'b0 || bus.s1_rdata !== '0 || bus.m_rready !== 1'b0) begin errors++; $display("FAIL mid_rst_r: rvalid %b rdata %h rready %b want 0", bus.s1_rvalid, bus.s1_rdata, bus.m_rready); end
    checks++; if (busy !== 1'b0 || err !== 1'b0 || bus.m_arvalid !== 1'b0 || bus.m_araddr !== '0) begin errors++; $display("FAIL mid_rst_status: busy %b err %b arvalid %b addr %h want 0", busy, err, bus.m_arvalid, bus.m_araddr); end
    checks++; if (bus.s0_arready !== 1'b0 || bus.s1_arready !== 1'b0) begin errors++; $display("FAIL mid_rst_arready: got %b%b want 00", bus.s1_arready, bus.s0_arready); end
    tick();
    bus.s0_arvalid = 1'b0;
    bus.m_rvalid = 1'b0;
    rst = 1'b0;
    tick();
    request(1, 32'h0000_90C0);
    ar_channel(1, 32'h0000_90C0, 0);
    r_burst(1, 32'hF000_0000, 8, 8, 0, 1'b0, ira);
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle_rvalid();
    test_round_robin();
    test_rready_toggle();
    test_errors();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
